// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the two-requester ALU share arbiter: opcodes, the
// legal-opcode limit and the FSM state encoding.
package alu_share_arbiter_pkg;

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_OR    = 4'd1;
    localparam logic [3:0] OP_NAND  = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_ADDU  = 4'd4;
    localparam logic [3:0] OP_SUBU  = 4'd5;
    localparam logic [3:0] OP_SLT   = 4'd6;
    localparam logic [3:0] OP_EQUAL = 4'd7;
    localparam logic [3:0] OP_SRA   = 4'd8;
    localparam logic [3:0] OP_SRAV  = 4'd9;
    localparam logic [3:0] OP_LUI   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;

    // Opcodes at or above this value are flagged as errors.
    localparam int OP_LIMIT = 12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, shared-ALU and response signals around the arbiter.
// slave = arbiter side, master = environment (requesters, ALU, consumer).
interface alu_share_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
);
    logic [1:0]        req_valid_i;
    logic [1:0]        req_ready_o;
    logic [DATA_W-1:0] req0_src1_i;
    logic [DATA_W-1:0] req0_src2_i;
    logic [CTRL_W-1:0] req0_ctrl_i;
    logic [DATA_W-1:0] req1_src1_i;
    logic [DATA_W-1:0] req1_src2_i;
    logic [CTRL_W-1:0] req1_ctrl_i;
    logic [DATA_W-1:0] alu_src1_o;
    logic [DATA_W-1:0] alu_src2_o;
    logic [CTRL_W-1:0] alu_ctrl_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_id_o;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_zero_o;
    logic              rsp_err_o;

    modport slave (
        input  req_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
               req1_src1_i, req1_src2_i, req1_ctrl_i,
               alu_result_i, alu_zero_i, rsp_ready_i,
        output req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
               rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req0_src1_i, req0_src2_i, req0_ctrl_i,
               req1_src1_i, req1_src2_i, req1_ctrl_i,
               alu_result_i, alu_zero_i, rsp_ready_i,
        input  req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
               rsp_valid_o, rsp_id_o, rsp_data_o, rsp_zero_o, rsp_err_o
    );

endinterface

// File: rtl/alu_share_arbiter_picker.sv
// alu_arb_picker: combinational two-way grant. A lone valid wins; on a tie the
// requester that was not granted last wins (last_grant_i=1 favours requester 0).
module alu_arb_picker (
    input  logic [1:0] req_valid_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = req_valid_i;
        if (&req_valid_i) begin
            grant_o = last_grant_i ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters; IDLE/BUSY/HOLD FSM.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin ties, else requester 0 wins.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic                clk_i,
    input  logic                rst_n,
    alu_share_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_id_q, rsp_id_d;
    logic              rsp_zero_q, rsp_zero_d;
    logic              rsp_err_q, rsp_err_d;

    logic [1:0] grant;
    logic       last_grant;
    logic       xfer;
    logic       xfer_id;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic last_grant_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (xfer) begin
            last_grant_q <= xfer_id;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b1;
`endif

    alu_arb_picker u_picker (
        .req_valid_i  (bus.req_valid_i),
        .last_grant_i (last_grant),
        .grant_o      (grant)
    );

    // Ready is masked by reset so nothing is offered while rst_n is low.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
        assign bus.req_ready_o[gi] = rst_n && (state_q == ST_IDLE) && grant[gi];
    end

    assign xfer    = |(bus.req_valid_i & bus.req_ready_o);
    assign xfer_id = bus.req_ready_o[1];

    always_comb begin
        state_d    = state_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        ctrl_d     = ctrl_q;
        id_d       = id_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        rsp_zero_d = rsp_zero_q;
        rsp_err_d  = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    state_d = ST_BUSY;
                    src1_d  = xfer_id ? bus.req1_src1_i : bus.req0_src1_i;
                    src2_d  = xfer_id ? bus.req1_src2_i : bus.req0_src2_i;
                    ctrl_d  = xfer_id ? bus.req1_ctrl_i : bus.req0_ctrl_i;
                    id_d    = xfer_id;
                end
            end
            ST_BUSY: begin
                state_d  = ST_HOLD;
                rsp_id_d = id_q;
                // Illegal opcodes still drive the ALU but get a fixed error result.
                if (ctrl_q >= CTRL_W'(OP_LIMIT)) begin
                    rsp_data_d = '0;
                    rsp_zero_d = 1'b1;
                    rsp_err_d  = 1'b1;
                end else begin
                    rsp_data_d = bus.alu_result_i;
                    rsp_zero_d = bus.alu_zero_i;
                    rsp_err_d  = 1'b0;
                end
            end
            ST_HOLD: begin
                if (bus.rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            ctrl_q     <= '0;
            id_q       <= 1'b0;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            rsp_zero_q <= 1'b0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            ctrl_q     <= ctrl_d;
            id_q       <= id_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            rsp_zero_q <= rsp_zero_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign bus.alu_src1_o  = (state_q == ST_BUSY) ? src1_q : '0;
    assign bus.alu_src2_o  = (state_q == ST_BUSY) ? src2_q : '0;
    assign bus.alu_ctrl_o  = (state_q == ST_BUSY) ? ctrl_q : '0;
    assign bus.rsp_valid_o = (state_q == ST_HOLD);
    assign bus.rsp_id_o    = rsp_id_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.rsp_zero_o  = rsp_zero_q;
    assign bus.rsp_err_o   = rsp_err_q;

endmodule
